// File: rtl/a2d_pkg.sv
// a2d_pkg -- shared types and helpers for the A2D conversion scheduler.
//   a2d_state_e  : scheduler FSM states
//   a2d_ptr_e    : round-robin channel pointer (left, right, battery)
//   CH_*_DEF     : default A2D channel numbers
//   TMO_DEF      : default spi_done timeout in cycles
//   a2d_cmd()    : builds the 16-bit command word for a channel
//   a2d_ptr_next(): round-robin successor of a channel pointer
package a2d_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WCMD  = 3'd2,
    S_GAP   = 3'd3,
    S_RD    = 3'd4,
    S_WRD   = 3'd5,
    S_STORE = 3'd6
  } a2d_state_e;

  typedef enum logic [1:0] {
    P_LFT  = 2'd0,
    P_RGHT = 2'd1,
    P_BATT = 2'd2
  } a2d_ptr_e;

  localparam logic [2:0]  CH_LFT_DEF  = 3'd0;
  localparam logic [2:0]  CH_RGHT_DEF = 3'd4;
  localparam logic [2:0]  CH_BATT_DEF = 3'd5;
  localparam int unsigned TMO_DEF     = 1023;

  // The ADC takes the channel in bits [13:11]; every other bit is zero.
  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  function automatic a2d_ptr_e a2d_ptr_next(input a2d_ptr_e p);
    case (p)
      P_LFT:   return P_RGHT;
      P_RGHT:  return P_BATT;
      default: return P_LFT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_tmo_cnt.sv
// a2d_tmo_cnt -- clearable, enabled up-counter with terminal-count flag.
//   clk   : clock
//   rst   : synchronous active-high reset
//   i_clr : synchronous clear (wins over i_en)
//   i_en  : count enable
//   o_tc  : high while the count equals TERM
// The counter holds at TERM so it can never wrap back below the threshold.
module a2d_tmo_cnt #(
  parameter int unsigned W    = 10,
  parameter int unsigned TERM = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_at_term;

  assign w_at_term = (r_cnt == W'(TERM));
  assign o_tc      = w_at_term;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/a2d_sched.sv
// a2d_sched -- round-robin A2D conversion scheduler over an SPI monarch.
//   clk       : sole clock (rising edge)
//   rst       : synchronous active-high reset
//   nxt       : request one conversion of the current round-robin channel
//   spi_wrt   : single-cycle start pulse to the SPI monarch
//   spi_cmd   : command word for the SPI monarch
//   spi_done  : single-cycle transaction-complete pulse from the SPI monarch
//   spi_rd    : word received in the finished transaction
//   lft_ld    : last left load-cell result
//   rght_ld   : last right load-cell result
//   batt      : last battery result
//   vld       : single-cycle pulse when a result register updates
//   busy      : high whenever the FSM is not idle
//   err       : sticky spi_done timeout flag, cleared only by rst
//   state_dbg : current FSM state
//
// SPI handshake: the scheduler raises spi_wrt for exactly one cycle with
// spi_cmd valid in that cycle and holding afterwards; the monarch answers
// with one spi_done pulse, sampled only in WCMD/WRD, and spi_rd is valid
// in that same cycle. spi_done seen in any other state is ignored.
//
// A conversion is two transactions: the first sends the channel, the
// second re-sends it and returns the sample for the channel of the first.
module a2d_sched
  import a2d_pkg::*;
#(
  parameter logic [2:0]  CH_LFT  = CH_LFT_DEF,
  parameter logic [2:0]  CH_RGHT = CH_RGHT_DEF,
  parameter logic [2:0]  CH_BATT = CH_BATT_DEF,
  parameter int unsigned TMO     = TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        vld,
  output logic        busy,
  output logic        err,
  output a2d_state_e  state_dbg
);

  localparam int unsigned TMO_W = (TMO < 2) ? 1 : $clog2(TMO + 1);

  a2d_state_e  r_state;
  a2d_ptr_e    r_ptr;
  logic        r_spi_wrt;
  logic [15:0] r_spi_cmd;
  logic [11:0] r_lft_ld;
  logic [11:0] r_rght_ld;
  logic [11:0] r_batt;
  logic        r_vld;
  logic        r_busy;
  logic        r_err;

  logic [2:0]  w_ch;
  logic        w_tmo_clr;
  logic        w_tmo_en;
  logic        w_tmo_tc;
  logic [3:0]  w_unused_rd_hi;

  // The ADC's upper nibble carries no sample data.
  assign w_unused_rd_hi = spi_rd[15:12];

  always_comb begin
    w_ch = CH_LFT;
    case (r_ptr)
      P_RGHT:  w_ch = CH_RGHT;
      P_BATT:  w_ch = CH_BATT;
      default: w_ch = CH_LFT;
    endcase
  end

  // Clearing in CMD/RD means the count is zero on the first wait cycle.
  assign w_tmo_clr = (r_state == S_CMD) || (r_state == S_RD);
  assign w_tmo_en  = (r_state == S_WCMD) || (r_state == S_WRD);

  a2d_tmo_cnt #(
    .W    (TMO_W),
    .TERM (TMO)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmo_clr),
    .i_en  (w_tmo_en),
    .o_tc  (w_tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= P_LFT;
      r_spi_wrt <= 1'b0;
      r_spi_cmd <= 16'h0000;
      r_lft_ld  <= 12'h000;
      r_rght_ld <= 12'h000;
      r_batt    <= 12'h000;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_spi_wrt <= 1'b0;
      r_vld     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (nxt) begin
            r_state   <= S_CMD;
            r_spi_wrt <= 1'b1;
            r_spi_cmd <= a2d_cmd(w_ch);
            r_busy    <= 1'b1;
          end
        end
        S_CMD: begin
          r_state <= S_WCMD;
        end
        S_WCMD: begin
          // spi_done is tested first so it beats a same-cycle timeout.
          if (spi_done) begin
            r_state <= S_GAP;
          end else if (w_tmo_tc) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        S_GAP: begin
          // Idle cycle lets SS_n deassert between transactions.
          r_state   <= S_RD;
          r_spi_wrt <= 1'b1;
        end
        S_RD: begin
          r_state <= S_WRD;
        end
        S_WRD: begin
          if (spi_done) begin
            r_state <= S_STORE;
            r_vld   <= 1'b1;
            case (r_ptr)
              P_RGHT:  r_rght_ld <= spi_rd[11:0];
              P_BATT:  r_batt    <= spi_rd[11:0];
              default: r_lft_ld  <= spi_rd[11:0];
            endcase
          end else if (w_tmo_tc) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        S_STORE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= a2d_ptr_next(r_ptr);
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_wrt   = r_spi_wrt;
  assign spi_cmd   = r_spi_cmd;
  assign lft_ld    = r_lft_ld;
  assign rght_ld   = r_rght_ld;
  assign batt      = r_batt;
  assign vld       = r_vld;
  assign busy      = r_busy;
  assign err       = r_err;
  assign state_dbg = r_state;

endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 Parameter CH_LFT, default 3'd0, A2D channel of the left load cell.
REQ-002 Parameter CH_RGHT, default 3'd4, A2D channel of the right load cell.
REQ-003 Parameter CH_BATT, default 3'd5, A2D channel of the battery divider.
REQ-004 Parameter TMO, default 1023, number of cycles to wait for spi_done before abort.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 nxt  in  1  single-cycle request to convert the current round-robin channel.
REQ-008 spi_wrt  out  1  single-cycle start pulse to the SPI monarch.
REQ-009 spi_cmd  out  16  word sent by the SPI monarch.
REQ-010 spi_done  in  1  single-cycle pulse when the SPI monarch finishes a transaction.
REQ-011 spi_rd  in  16  word received in the finished transaction.
REQ-012 lft_ld, rght_ld, batt  out  12 each  last converted result per channel.
REQ-013 vld  out  1  single-cycle pulse when a result register updates.
REQ-014 busy  out  1  high while a conversion is in progress.
REQ-015 err  out  1  sticky timeout flag; cleared only by reset.

Function
REQ-016 State machine states: IDLE, CMD, WCMD, GAP, RD, WRD, STORE.
REQ-017 IDLE: nxt=1 -> CMD; otherwise stay.
REQ-018 CMD: spi_wrt=1 for exactly one cycle; spi_cmd = {2'b00, ch[2:0], 11'h000}; -> WCMD.
REQ-019 WCMD: spi_done=1 -> GAP.
REQ-020 GAP: one idle cycle (SS_n deassert time) -> RD.
REQ-021 RD: spi_wrt=1 for one cycle; spi_cmd holds the same word as in CMD; -> WRD.
REQ-022 WRD: spi_done=1 -> STORE, and spi_rd[11:0] is captured in the same cycle.
REQ-023 STORE: the selected result register updates; vld=1 for one cycle; the channel pointer advances LFT->RGHT->BATT->LFT; -> IDLE.
REQ-024 Latency: vld rises exactly 1 cycle after the second spi_done.
REQ-025 spi_rd[15:12] is discarded; results are 12-bit unsigned with no arithmetic.
REQ-026 busy=1 in every state except IDLE.
REQ-027 nxt while busy is ignored and is not queued.
REQ-028 spi_done in IDLE, CMD, GAP, RD or STORE is ignored.
REQ-029 A timeout counter clears on every entry to WCMD or WRD and increments each cycle spent in those states.
REQ-030 Timeout: the counter reaches TMO without spi_done -> err=1, -> IDLE, no result update, no vld, channel pointer not advanced.
REQ-031 spi_done and the timeout in the same cycle: spi_done wins and err is not set.
REQ-032 nxt in the same cycle as the STORE->IDLE transition is ignored; a new conversion starts on the first nxt seen in IDLE.

Reset
REQ-033 On rst=1: state=IDLE, pointer=LFT, spi_wrt=0, spi_cmd=16'h0000, lft_ld/rght_ld/batt=12'h000, vld=0, busy=0, err=0, timeout counter=0.
REQ-034 rst mid-conversion aborts the conversion immediately; a spi_done arriving later is ignored in IDLE.

Structure
REQ-035 A shared package a2d_pkg holds the state enum, the default channel constants and the helper that builds the command word.
REQ-036 One sub-module, a2d_tmo_cnt: a clearable, enabled counter with a terminal-count flag.

Verification
REQ-037 After reset, 3 nxt pulses with a bus model (ADC128S) supplying 12'hA5C / 12'h3F1 / 12'h7FF -> lft_ld=A5C, rght_ld=3F1, batt=7FF, 3 vld pulses, spi_cmd channel fields 0,4,5.
REQ-038 A 4th nxt -> channel 0 again (wrap-around); lft_ld updates while rght_ld and batt hold.
REQ-039 nxt pulsed every cycle during a conversion -> exactly one conversion and one vld.
REQ-040 spi_done suppressed after CMD with TMO=15 -> err=1 16 cycles after entering WCMD, busy=0, no vld, the next nxt still targets the same channel.
REQ-041 rst asserted while in WRD -> next cycle all outputs at reset values; a late spi_done causes no vld.
REQ-042 Count every spi_wrt pulse -> exactly 2 per conversion, each a single cycle, with exactly one GAP cycle between the first spi_done and the second spi_wrt.
